mmio_port_unit: RTL and testbench
=================================

Name: mmio_port_unit

Overview:
- Memory-mapped I/O peripheral sitting directly downstream of the single-cycle MIPS core's data path, in parallel with the data RAM.
- Consumes the ALU result as address, plus the rs2 store data and the MemRead/MemWrite controls.
- Drives the 32-bit PortOut pins and a synchronized 8-bit PortIn.
- Provides a compare timer and sticky status flags with an interrupt line. The read mux back to the core is combinational, so single-cycle lw/sw still work.

Parameters:
- IO_BASE, 32'h1001_0040: word-aligned base of the 32-byte register window; bits [4:0] must be 0.
- TIMER_RST_CMP, 32'hFFFF_FFFF: reset value of TIMER_CMP.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Address  input  32  byte address from the ALU result.
- WriteData  input  32  store data (rs2).
- MemWrite  input  1  store strobe.
- MemRead  input  1  load strobe.
- PortIn  input  8  asynchronous external input pins.
- ReadData  output  32  combinational register read data.
- Hit  output  1  address decodes to a mapped register; the core muxes ReadData over RAM data when 1.
- PortOut  output  32  registered output port.
- IRQ  output  1  level interrupt request.

Behaviour:
Decode:
- Hit = (Address[31:5] == IO_BASE[31:5]) && (Address[4:2] <= 5). Address[1:0] is ignored.
- Offsets 0x18–0x1C give Hit=0: writes are ignored and reads are not claimed.

Register map (word offset, access):
- 0x00 PORT_OUT, RW, drives PortOut.
- 0x04 PORT_IN, RO, {24'b0, sync2}.
- 0x08 STATUS, W1C: bit0 IN_CHG, bit1 TMR_MATCH, other bits read 0.
- 0x0C TIMER_CNT, RW.
- 0x10 TIMER_CMP, RW.
- 0x14 CTRL, RW, bits[3:0] only: bit0 TMR_EN, bit1 AUTO_RELOAD, bit2 IN_IRQ_EN, bit3 TMR_IRQ_EN.

Reads:
- ReadData = selected register when MemRead && Hit, else 32'h0.
- Zero-latency combinational path from register state.
- Reads have no side effects.

Writes:
- Take effect on the rising clk edge when MemWrite && Hit.
- A write to PORT_IN is ignored.

Reset (synchronous, reset=1 at an edge):
- PORT_OUT=0, STATUS=0, TIMER_CNT=0, TIMER_CMP=TIMER_RST_CMP, CTRL=0.
- sync1/sync2/sync3 = 0.
- Resulting outputs: PortOut=0, IRQ=0. ReadData and Hit stay purely combinational.
- Reset overrides any simultaneous write or event.

Input synchronizer:
- Three-flop chain: sync1<=PortIn, sync2<=sync1, sync3<=sync2.
- A PortIn change is readable in PORT_IN 2 edges later.
- in_event = (sync2 != sync3); IN_CHG is set at the edge where in_event is true, i.e. 3 edges after the change.

Timer, each edge with TMR_EN=1:
- If TIMER_CNT == TIMER_CMP: TMR_MATCH is set, and TIMER_CNT goes to 0 if AUTO_RELOAD, else TIMER_CNT+1.
- Otherwise TIMER_CNT+1, wrapping 32'hFFFF_FFFF -> 0 with no flag.
- TMR_EN=0 freezes the count, and no match is generated.
- A software write to TIMER_CNT in the same cycle wins over increment/reload. The match check that cycle still uses the pre-write count.
- A write to TIMER_CMP takes effect for the next cycle's comparison.

STATUS W1C:
- Writing 1 clears the corresponding bit; writing 0 has no effect.
- If a set event and a W1C clear coincide, the set wins and the bit stays 1.

IRQ:
- IRQ = (IN_CHG & IN_IRQ_EN) | (TMR_MATCH & TMR_IRQ_EN), combinational from registers.

Simultaneous MemRead && MemWrite:
- The read returns the pre-write value; the write commits at the edge.

Decomposition:
- Shared package mmio_pkg holds:
  - the offset constants OFS_PORT_OUT..OFS_CTRL;
  - STATUS/CTRL bit indices;
  - the default IO_BASE.
- The core top-level and the software tests import the same constants.
- One natural sub-module: mmio_timer (count/compare/reload, inputs en, auto_reload, wr_cnt, wr_cmp, data; outputs cnt, cmp, match_pulse).
- The synchronizer and register file stay in mmio_port_unit.

Test Plan:
1. Reset, then read all six offsets with MemRead=1 -> PORT_OUT/PORT_IN/STATUS/TIMER_CNT/CTRL read 0, TIMER_CMP reads FFFF_FFFF, PortOut=0, IRQ=0.
2. sw 32'hDEAD_BEEF to IO_BASE+0x00 -> PortOut=DEAD_BEEF after that edge. A write to IO_BASE+0x18 leaves all registers unchanged, and Hit=0 there.
3. PortIn 0x00->0xA5 between edges -> PORT_IN reads 0x00 after 1 edge and 0x000000A5 after 2. STATUS bit0=1 after 3. With IN_IRQ_EN=1, IRQ=1. Writing 0x1 to STATUS clears it and IRQ drops.
4. CMP=3, CTRL=0b1011 (en, reload, tmr_irq) -> CNT sequence 0,1,2,3,0,1... TMR_MATCH set on the edge where CNT==3, IRQ=1.
5. CMP=2, CTRL=0b0001: CNT reaches 2 then 3 (no reload). Writing CNT=FFFF_FFFE gives FFFF_FFFF then 0 with no match. W1C of TMR_MATCH in the same cycle as a new match -> bit remains 1.
6. Assert reset mid-count (CNT=7, PORT_OUT=5, IN_CHG=1) with a simultaneous sw to TIMER_CNT -> next edge: all registers at reset values, PortOut=0, IRQ=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port unit: register offsets, bit positions and decode helper.
// Imported by the RTL and by software-facing tests so both agree on the map.
package mmio_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT       = 32'h1001_0040;
    localparam logic [31:0] TIMER_RST_CMP_DEFAULT = 32'hFFFF_FFFF;

    localparam logic [4:0] OFS_PORT_OUT  = 5'h00;
    localparam logic [4:0] OFS_PORT_IN   = 5'h04;
    localparam logic [4:0] OFS_STATUS    = 5'h08;
    localparam logic [4:0] OFS_TIMER_CNT = 5'h0C;
    localparam logic [4:0] OFS_TIMER_CMP = 5'h10;
    localparam logic [4:0] OFS_CTRL      = 5'h14;

    // Word selects derived from the byte offsets; Address[1:0] never takes part in decode.
    localparam logic [2:0] SEL_PORT_OUT  = OFS_PORT_OUT[4:2];
    localparam logic [2:0] SEL_PORT_IN   = OFS_PORT_IN[4:2];
    localparam logic [2:0] SEL_STATUS    = OFS_STATUS[4:2];
    localparam logic [2:0] SEL_TIMER_CNT = OFS_TIMER_CNT[4:2];
    localparam logic [2:0] SEL_TIMER_CMP = OFS_TIMER_CMP[4:2];
    localparam logic [2:0] SEL_CTRL      = OFS_CTRL[4:2];

    localparam int unsigned STS_IN_CHG    = 0;
    localparam int unsigned STS_TMR_MATCH = 1;

    localparam int unsigned CTRL_TMR_EN      = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IN_IRQ_EN   = 2;
    localparam int unsigned CTRL_TMR_IRQ_EN  = 3;

    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
        return (addr[31:5] == base[31:5]) && (addr[4:2] <= SEL_CTRL);
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running compare timer: increments while enabled, flags a match when count equals compare.
// Software writes to the count win over increment/reload; the match still sees the old count.
module mmio_timer #(
    parameter logic [31:0] RST_CMP = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic        auto_reload_i,
    input  logic        wr_cnt_i,
    input  logic        wr_cmp_i,
    input  logic [31:0] data_i,
    output logic [31:0] cnt_o,
    output logic [31:0] cmp_o,
    output logic        match_pulse_o
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic        match;

    assign match = en_i && (cnt_q == cmp_q);

    always_comb begin
        cnt_d = cnt_q;
        cmp_d = cmp_q;
        if (en_i) begin
            cnt_d = (match && auto_reload_i) ? 32'd0 : cnt_q + 32'd1;
        end
        if (wr_cnt_i) begin
            cnt_d = data_i;
        end
        if (wr_cmp_i) begin
            cmp_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= 32'd0;
            cmp_q <= RST_CMP;
        end else begin
            cnt_q <= cnt_d;
            cmp_q <= cmp_d;
        end
    end

    assign cnt_o         = cnt_q;
    assign cmp_o         = cmp_q;
    assign match_pulse_o = match;

endmodule

// File: rtl/mmio_port_unit.sv
// Memory-mapped port peripheral beside the data RAM: output port, synchronized input port,
// compare timer and sticky status with a level IRQ. Reads are combinational for single-cycle lw.
module mmio_port_unit
    import mmio_pkg::*;
#(
    parameter logic [31:0] IO_BASE       = IO_BASE_DEFAULT,
    parameter logic [31:0] TIMER_RST_CMP = TIMER_RST_CMP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut,
    output logic        IRQ
);

    logic [7:0]  sync1_q, sync2_q, sync3_q;
    logic [31:0] port_out_q, port_out_d;
    logic [1:0]  status_q, status_d;
    logic [3:0]  ctrl_q, ctrl_d;

    logic        hit;
    logic [2:0]  sel;
    logic        wr;
    logic        in_event;
    logic [1:0]  w1c_mask;
    logic [31:0] tmr_cnt, tmr_cmp;
    logic        tmr_match;
    logic        addr_lsb_unused;

    assign hit             = addr_hit(Address, IO_BASE);
    assign sel             = Address[4:2];
    assign wr              = MemWrite && hit;
    assign in_event        = (sync2_q != sync3_q);
    assign addr_lsb_unused = ^Address[1:0];

    mmio_timer #(
        .RST_CMP(TIMER_RST_CMP)
    ) u_timer (
        .clk_i         (clk),
        .reset_i       (reset),
        .en_i          (ctrl_q[CTRL_TMR_EN]),
        .auto_reload_i (ctrl_q[CTRL_AUTO_RELOAD]),
        .wr_cnt_i      (wr && (sel == SEL_TIMER_CNT)),
        .wr_cmp_i      (wr && (sel == SEL_TIMER_CMP)),
        .data_i        (WriteData),
        .cnt_o         (tmr_cnt),
        .cmp_o         (tmr_cmp),
        .match_pulse_o (tmr_match)
    );

    // Set events are applied after the W1C clear so a coincident event keeps the bit at 1.
    always_comb begin
        port_out_d = port_out_q;
        ctrl_d     = ctrl_q;
        w1c_mask   = 2'b00;
        if (wr && (sel == SEL_PORT_OUT)) begin
            port_out_d = WriteData;
        end
        if (wr && (sel == SEL_CTRL)) begin
            ctrl_d = WriteData[3:0];
        end
        if (wr && (sel == SEL_STATUS)) begin
            w1c_mask = WriteData[1:0];
        end
        status_d = status_q & ~w1c_mask;
        if (in_event) begin
            status_d[STS_IN_CHG] = 1'b1;
        end
        if (tmr_match) begin
            status_d[STS_TMR_MATCH] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 8'd0;
            sync2_q    <= 8'd0;
            sync3_q    <= 8'd0;
            port_out_q <= 32'd0;
            status_q   <= 2'b00;
            ctrl_q     <= 4'd0;
        end else begin
            sync1_q    <= PortIn;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            port_out_q <= port_out_d;
            status_q   <= status_d;
            ctrl_q     <= ctrl_d;
        end
    end

    always_comb begin
        ReadData = 32'd0;
        if (MemRead && hit) begin
            case (sel)
                SEL_PORT_OUT:  ReadData = port_out_q;
                SEL_PORT_IN:   ReadData = {24'd0, sync2_q};
                SEL_STATUS:    ReadData = {30'd0, status_q};
                SEL_TIMER_CNT: ReadData = tmr_cnt;
                SEL_TIMER_CMP: ReadData = tmr_cmp;
                SEL_CTRL:      ReadData = {28'd0, ctrl_q};
                default:       ReadData = 32'd0;
            endcase
        end
    end

    assign Hit     = hit;
    assign PortOut = port_out_q;
    assign IRQ     = (status_q[STS_IN_CHG]    & ctrl_q[CTRL_IN_IRQ_EN]) |
                     (status_q[STS_TMR_MATCH] & ctrl_q[CTRL_TMR_IRQ_EN]);

endmodule

// File: tb/tb_mmio_port_unit.sv
// Directed bench for mmio_port_unit: expected read values are queued as each access is driven
// and popped when the combinational read data is sampled.
module tb_mmio_port_unit;
    import mmio_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0040;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [7:0]  PortIn = 8'd0;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        IRQ;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mmio_port_unit #(
        .IO_BASE(BASE),
        .TIMER_RST_CMP(32'hFFFF_FFFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortOut   (PortOut),
        .IRQ       (IRQ)
    );

    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] ofs, input logic [31:0] data);
        Address   = BASE + {27'd0, ofs};
        WriteData = data;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] ofs, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        Address = BASE + {27'd0, ofs};
        MemRead = 1'b1;
        #1;
        e = exp_q.pop_front();
        chk(tag, ReadData, e);
        MemRead = 1'b0;
    endtask

    initial begin
        int m;

        step();
        step();
        reset = 1'b0;

        // Reset values
        rd("rst_port_out", OFS_PORT_OUT, 32'h0);
        rd("rst_port_in", OFS_PORT_IN, 32'h0);
        rd("rst_status", OFS_STATUS, 32'h0);
        rd("rst_cnt", OFS_TIMER_CNT, 32'h0);
        rd("rst_cmp", OFS_TIMER_CMP, 32'hFFFF_FFFF);
        rd("rst_ctrl", OFS_CTRL, 32'h0);
        chk("rst_portout_pin", PortOut, 32'h0);
        chk("rst_irq", {31'd0, IRQ}, 32'h0);

        // Output port, decode boundaries
        wr(OFS_PORT_OUT, 32'hDEAD_BEEF);
        chk("portout_pin", PortOut, 32'hDEAD_BEEF);
        Address = BASE + 32'h17; #1;
        chk("hit_ctrl_lsb", {31'd0, Hit}, 32'd1);
        Address = BASE + 32'h18; #1;
        chk("hit_0x18", {31'd0, Hit}, 32'd0);
        Address = BASE + 32'h20; #1;
        chk("hit_next_window", {31'd0, Hit}, 32'd0);
        rd("rd_0x18", 5'h18, 32'h0);
        wr(5'h18, 32'h1234_5678);
        rd("after_0x18_port_out", OFS_PORT_OUT, 32'hDEAD_BEEF);
        rd("after_0x18_ctrl", OFS_CTRL, 32'h0);
        rd("after_0x18_cmp", OFS_TIMER_CMP, 32'hFFFF_FFFF);

        // Read during write returns the old value
        exp_q.push_back(32'hDEAD_BEEF);
        Address = BASE + {27'd0, OFS_PORT_OUT};
        WriteData = 32'h0000_1234;
        MemWrite = 1'b1;
        MemRead = 1'b1;
        #1;
        chk("rdwr_old", ReadData, exp_q.pop_front());
        step();
        MemWrite = 1'b0;
        MemRead = 1'b0;
        chk("rdwr_new_pin", PortOut, 32'h0000_1234);

        // Input synchronizer and IN_CHG
        wr(OFS_CTRL, 32'h4);
        PortIn = 8'hA5;
        step();
        rd("pin_1edge", OFS_PORT_IN, 32'h0);
        step();
        rd("pin_2edge", OFS_PORT_IN, 32'hA5);
        rd("status_2edge", OFS_STATUS, 32'h0);
        chk("irq_2edge", {31'd0, IRQ}, 32'd0);
        step();
        rd("status_3edge", OFS_STATUS, 32'h1);
        chk("irq_in_chg", {31'd0, IRQ}, 32'd1);
        wr(OFS_STATUS, 32'h1);
        rd("status_w1c_in", OFS_STATUS, 32'h0);
        chk("irq_cleared", {31'd0, IRQ}, 32'd0);
        wr(OFS_PORT_IN, 32'hFF);
        rd("pin_ro", OFS_PORT_IN, 32'hA5);

        // Auto-reload timer
        wr(OFS_CTRL, 32'h0);
        wr(OFS_TIMER_CMP, 32'd3);
        wr(OFS_CTRL, 32'hB);
        m = 0;
        for (int i = 0; i < 6; i++) begin
            rd("reload_cnt", OFS_TIMER_CNT, m);
            if (m == 3) rd("pre_match_status", OFS_STATUS, 32'h0);
            step();
            m = (m == 3) ? 0 : m + 1;
        end
        rd("reload_status", OFS_STATUS, 32'h2);
        chk("irq_tmr", {31'd0, IRQ}, 32'd1);

        // Freeze, no reload, wrap, set-vs-clear
        wr(OFS_CTRL, 32'h0);
        rd("freeze_a", OFS_TIMER_CNT, 32'd3);
        step();
        rd("freeze_b", OFS_TIMER_CNT, 32'd3);
        wr(OFS_STATUS, 32'h3);
        rd("status_clr_all", OFS_STATUS, 32'h0);
        wr(OFS_TIMER_CNT, 32'd0);
        wr(OFS_TIMER_CMP, 32'd2);
        wr(OFS_CTRL, 32'h1);
        step();
        step();
        step();
        rd("noreload_cnt", OFS_TIMER_CNT, 32'd3);
        rd("noreload_status", OFS_STATUS, 32'h2);
        chk("irq_masked", {31'd0, IRQ}, 32'd0);
        wr(OFS_STATUS, 32'h2);
        rd("status_w1c_tmr", OFS_STATUS, 32'h0);
        wr(OFS_TIMER_CNT, 32'hFFFF_FFFE);
        rd("cnt_written", OFS_TIMER_CNT, 32'hFFFF_FFFE);
        step();
        rd("cnt_max", OFS_TIMER_CNT, 32'hFFFF_FFFF);
        step();
        rd("cnt_wrap", OFS_TIMER_CNT, 32'h0);
        rd("wrap_no_match", OFS_STATUS, 32'h0);
        step();
        step();
        wr(OFS_STATUS, 32'h2);
        rd("set_beats_clear", OFS_STATUS, 32'h2);
        rd("post_match_cnt", OFS_TIMER_CNT, 32'd3);

        // Reset mid-activity with a simultaneous write
        wr(OFS_CTRL, 32'h0);
        wr(OFS_TIMER_CNT, 32'd7);
        wr(OFS_PORT_OUT, 32'd5);
        PortIn = 8'h5A;
        step();
        step();
        step();
        rd("pre_rst_status", OFS_STATUS, 32'h3);
        wr(OFS_CTRL, 32'hC);
        chk("pre_rst_irq", {31'd0, IRQ}, 32'd1);
        rd("pre_rst_cnt", OFS_TIMER_CNT, 32'd7);
        chk("pre_rst_portout", PortOut, 32'd5);
        Address = BASE + {27'd0, OFS_TIMER_CNT};
        WriteData = 32'h55;
        MemWrite = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        MemWrite = 1'b0;
        rd("r2_port_out", OFS_PORT_OUT, 32'h0);
        rd("r2_port_in", OFS_PORT_IN, 32'h0);
        rd("r2_status", OFS_STATUS, 32'h0);
        rd("r2_cnt", OFS_TIMER_CNT, 32'h0);
        rd("r2_cmp", OFS_TIMER_CMP, 32'hFFFF_FFFF);
        rd("r2_ctrl", OFS_CTRL, 32'h0);
        chk("r2_portout_pin", PortOut, 32'h0);
        chk("r2_irq", {31'd0, IRQ}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
